// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares one 32-bit UART word transmitter among
//   NREQ requesters. It runs one word at a time: grant (IDLE), start pulse
//   (START), wait for the transmitter to finish (WAIT), then an optional
//   idle gap (GAP) before the next grant.
// Parameters
//   NREQ        number of requesters (2..8)
//   GAP_CYCLES  minimum idle clocks between words (0..65535)
// Ports
//   clk, reset    rising-edge clock, synchronous active-high reset
//   req_valid     per-requester word-pending flag
//   req_data      requester i word in slice [i]
//   req_ready     one-hot accept pulse; the word is taken this cycle
//   req_done      one-hot pulse when the granted word has left the line
//   tx_start      one-cycle start pulse to the transmitter
//   tx_data       word to the transmitter, byte 0 in [7:0]
//   tx_end        one-cycle completion pulse from the transmitter
//   busy          high in every state except IDLE
//   grant_id      requester currently being served
//   err_spurious  sticky; tx_end seen outside WAIT
module uart_tx_arbiter #(
  parameter int NREQ       = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0][31:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      req_done,
  output logic                 tx_start,
  output logic [31:0]          tx_data,
  input  logic                 tx_end,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 err_spurious
);

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  state_t        r_state, w_next;
  logic [2:0]    r_rr_ptr;
  logic [2:0]    r_grant;
  logic [31:0]   r_tx_data;
  logic [15:0]   r_gap_cnt;
  logic          r_err;

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [2:0]        w_off;
  logic [3:0]        w_sum;
  logic [2:0]        w_sel;
  logic              w_found;
  logic [31:0]       w_word;

  // Rotate the valid vector so bit 0 is the requester at rr_ptr; the lowest
  // set bit of the rotated vector is then the round-robin winner offset.
  assign w_dbl   = {req_valid, req_valid} >> r_rr_ptr;
  assign w_rot   = w_dbl[NREQ-1:0];
  assign w_found = |req_valid;

  always_comb begin
    w_off = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (w_rot[k]) w_off = 3'(k);
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    if (w_sum >= 4'(NREQ)) w_sum = w_sum - 4'(NREQ);
    w_sel = w_sum[2:0];
  end

  always_comb begin
    w_word = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_sel == 3'(i)) w_word = req_data[i];
  end

  // Next state and combinational strobes
  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    req_done  = '0;
    tx_start  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          for (int i = 0; i < NREQ; i++)
            req_ready[i] = (w_sel == 3'(i));
          w_next = START;
        end
      end
      START: begin
        tx_start = 1'b1;
        w_next   = WAIT;
      end
      WAIT: begin
        if (tx_end) begin
          for (int i = 0; i < NREQ; i++)
            req_done[i] = (r_grant == 3'(i));
          w_next = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (r_gap_cnt == 16'd0) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_grant   <= '0;
      r_tx_data <= '0;
      r_gap_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (tx_end && r_state != WAIT) r_err <= 1'b1;
      case (r_state)
        IDLE: begin
          // tx_data/grant_id only change here, so they hold through the word
          if (w_found) begin
            r_tx_data <= w_word;
            r_grant   <= w_sel;
          end
        end
        WAIT: begin
          if (tx_end) begin
            r_rr_ptr <= (r_grant == 3'(NREQ - 1)) ? 3'd0 : r_grant + 3'd1;
            if (GAP_CYCLES > 0) r_gap_cnt <= 16'(GAP_CYCLES - 1);
          end
        end
        GAP: begin
          if (r_gap_cnt != 16'd0) r_gap_cnt <= r_gap_cnt - 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign tx_data      = r_tx_data;
  assign grant_id     = r_grant;
  assign busy         = (r_state != IDLE);
  assign err_spurious = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: three instances (GAP 16, 0, 3), each with a
// simple word-transmitter model that reads one byte every two clocks from
// tx_data and pulses tx_end after the fourth byte.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]       rv    [3];
  logic [N-1:0][31:0] rd    [3];
  logic [N-1:0]       rrdy  [3];
  logic [N-1:0]       rdone [3];
  logic               ts    [3];
  logic [31:0]        td    [3];
  logic               te    [3];
  logic               bsy   [3];
  logic [2:0]         gid   [3];
  logic               err   [3];
  logic               fe    [3];
  logic               tm_end[3];
  logic               tm_act[3];
  int                 tm_cnt[3];
  logic [31:0]        cap   [3];

  int compared   = 0;
  int mismatched = 0;

  for (genvar g = 0; g < 3; g++) begin : G
    assign te[g] = tm_end[g] | fe[g];
    uart_tx_arbiter #(.NREQ(N), .GAP_CYCLES(g == 0 ? 16 : (g == 1 ? 0 : 3))) u (
      .clk(clk), .reset(reset), .req_valid(rv[g]), .req_data(rd[g]),
      .req_ready(rrdy[g]), .req_done(rdone[g]), .tx_start(ts[g]),
      .tx_data(td[g]), .tx_end(te[g]), .busy(bsy[g]), .grant_id(gid[g]),
      .err_spurious(err[g]));

    // transmitter model: byte b is read from tx_data at count 2b+1
    always @(posedge clk) begin
      if (reset) begin
        tm_act[g] <= 1'b0;
        tm_cnt[g] <= 0;
        tm_end[g] <= 1'b0;
      end else begin
        tm_end[g] <= 1'b0;
        if (tm_act[g]) begin
          if (tm_cnt[g][0]) cap[g][8*(tm_cnt[g]/2) +: 8] <= td[g][8*(tm_cnt[g]/2) +: 8];
          tm_cnt[g] <= tm_cnt[g] + 1;
          if (tm_cnt[g] == 7) begin
            tm_act[g] <= 1'b0;
            tm_end[g] <= 1'b1;
          end
        end else if (ts[g]) begin
          tm_act[g] <= 1'b1;
          tm_cnt[g] <= 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    compared++;
    mismatched++;
    $display("FAIL %s: timed out, expected event", nm);
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (bsy[d] && n < 300) begin @(negedge clk); n++; end
    if (bsy[d]) timeout("wait_idle");
  endtask

  task automatic wait_done(input int d);
    int n = 0;
    while (rdone[d] == '0 && n < 200) begin @(negedge clk); n++; end
    if (rdone[d] == '0) timeout("wait_done");
  endtask

  // One full handshake: request, grant, start, bytes, done.
  task automatic run_word(input int d, input logic [N-1:0] v,
                          input logic [N-1:0] exp, input string nm);
    int ei = 0;
    for (int i = 0; i < N; i++) if (exp[i]) ei = i;
    wait_idle(d);
    @(posedge clk); #1;
    rv[d] = v;
    @(negedge clk);
    chk({nm, " ready"}, 64'(rrdy[d]), 64'(exp));
    @(posedge clk); #1;
    rv[d] = '0;
    @(negedge clk);
    chk({nm, " tx_start"}, 64'(ts[d]), 64'd1);
    chk({nm, " grant_id"}, 64'(gid[d]), 64'(ei));
    chk({nm, " tx_data"}, 64'(td[d]), 64'(rd[d][ei]));
    wait_done(d);
    chk({nm, " done"}, 64'(rdone[d]), 64'(exp));
    chk({nm, " line word"}, 64'(cap[d]), 64'(rd[d][ei]));
    chk({nm, " tx_data held"}, 64'(td[d]), 64'(rd[d][ei]));
  endtask

  // Word from req 0, then re-request; count GAP cycles before next ready.
  task automatic gap_chk(input int d, input int expn, input string nm);
    int n = 0;
    rd[d][0] = $urandom;
    run_word(d, 4'b0001, 4'b0001, nm);
    rv[d] = 4'b0001;
    @(negedge clk);
    while (rrdy[d] == '0 && n < 50) begin n++; @(negedge clk); end
    chk({nm, " gap cycles"}, 64'(n), 64'(expn));
    chk({nm, " next ready"}, 64'(rrdy[d]), 64'd1);
    @(posedge clk); #1;
    rv[d] = '0;
    wait_done(d);
    chk({nm, " next done"}, 64'(rdone[d]), 64'd1);
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] exp_ready;
  } vec_t;

  vec_t vt[10];

  initial begin
    int n;
    int ptr, gidx, cyc, idle_from, sel;
    logic inflight;
    logic [31:0] gword;
    logic [N-1:0] exp_ready, exp_done, taken;
    logic exp_busy;

    // rr_ptr evolves from 0 after reset; each row's winner advances it
    vt[0] = '{4'b0001, 4'b0001};
    vt[1] = '{4'b1111, 4'b0010};
    vt[2] = '{4'b1111, 4'b0100};
    vt[3] = '{4'b1111, 4'b1000};
    vt[4] = '{4'b1111, 4'b0001};
    vt[5] = '{4'b1001, 4'b1000};  // ptr 1: req 3 before req 0
    vt[6] = '{4'b1001, 4'b0001};
    vt[7] = '{4'b0100, 4'b0100};
    vt[8] = '{4'b0011, 4'b0001};  // ptr 3 wraps to 0
    vt[9] = '{4'b0110, 4'b0010};

    for (int d = 0; d < 3; d++) begin
      rv[d] = '0; rd[d] = '0; fe[d] = 1'b0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // reset state
    for (int d = 0; d < 3; d++) begin
      chk("rst busy", 64'(bsy[d]), 64'd0);
      chk("rst tx_data", 64'(td[d]), 64'd0);
      chk("rst grant_id", 64'(gid[d]), 64'd0);
      chk("rst err", 64'(err[d]), 64'd0);
      chk("rst ready", 64'(rrdy[d]), 64'd0);
      chk("rst done", 64'(rdone[d]), 64'd0);
      chk("rst tx_start", 64'(ts[d]), 64'd0);
    end

    // single word, GAP 16
    rd[0][0] = 32'hDEADBEEF;
    run_word(0, 4'b0001, 4'b0001, "single");
    chk("single byte0", 64'(cap[0][7:0]), 64'hEF);
    chk("single byte3", 64'(cap[0][31:24]), 64'hDE);
    n = 0;
    @(negedge clk);
    while (bsy[0] && n < 100) begin n++; @(negedge clk); end
    chk("single gap16 busy", 64'(n), 64'd16);

    // round-robin table, GAP 0
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < N; i++) rd[1][i] = $urandom;
      run_word(1, vt[v].valid, vt[v].exp_ready, $sformatf("rr[%0d]", v));
    end

    // gap timing
    gap_chk(2, 3, "gap3");
    gap_chk(1, 0, "gap0");

    // spurious tx_end in IDLE
    wait_idle(1);
    @(posedge clk); #1;
    fe[1] = 1'b1;
    @(negedge clk);
    chk("spur done", 64'(rdone[1]), 64'd0);
    @(posedge clk); #1;
    fe[1] = 1'b0;
    @(negedge clk);
    chk("spur err", 64'(err[1]), 64'd1);
    chk("spur busy", 64'(bsy[1]), 64'd0);
    repeat (5) @(negedge clk);
    chk("spur err sticky", 64'(err[1]), 64'd1);

    // reset mid-word (req 2 granted, reset on byte 2)
    wait_idle(0);
    @(posedge clk); #1;
    rd[0][2] = $urandom;
    rv[0] = 4'b0100;
    @(negedge clk);
    chk("midrst ready", 64'(rrdy[0]), 64'b0100);
    @(posedge clk); #1;
    rv[0] = '0;
    n = 0;
    while (tm_cnt[0] != 4 && n < 50) begin @(negedge clk); n++; end
    if (tm_cnt[0] != 4) timeout("midrst byte2");
    chk("midrst busy before", 64'(bsy[0]), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst done during", 64'(rdone[0]), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst busy", 64'(bsy[0]), 64'd0);
    chk("midrst tx_data", 64'(td[0]), 64'd0);
    chk("midrst grant_id", 64'(gid[0]), 64'd0);
    chk("midrst done", 64'(rdone[0]), 64'd0);
    for (int i = 0; i < N; i++) rd[0][i] = $urandom;
    run_word(0, 4'b1111, 4'b0001, "post_rst");  // rr_ptr back at 0

    // randomized traffic on GAP 3 against a transaction-level model
    ptr = 0; inflight = 1'b0; gidx = 0; gword = '0; cyc = 0; idle_from = 0;
    taken = '0;
    repeat (1500) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (taken[i]) begin
          taken[i] = 1'b0;
          if ($urandom_range(1, 0) == 1) begin rv[2][i] = 1'b1; rd[2][i] = $urandom; end
          else rv[2][i] = 1'b0;
        end else if (rv[2][i]) begin
          if ($urandom_range(15, 0) == 0) rv[2][i] = 1'b0;  // cancel
        end else if ($urandom_range(2, 0) == 0) begin
          rv[2][i] = 1'b1; rd[2][i] = $urandom;
        end
      end
      @(negedge clk);
      cyc++;
      exp_ready = '0;
      sel = 0;
      if (!inflight && cyc >= idle_from)
        for (int k = 0; k < N; k++)
          if (exp_ready == '0 && rv[2][(ptr + k) % N]) begin
            sel = (ptr + k) % N;
            exp_ready[sel] = 1'b1;
          end
      exp_done = '0;
      if (inflight && te[2]) exp_done[gidx] = 1'b1;
      exp_busy = inflight || (cyc < idle_from);
      chk("rnd ready", 64'(rrdy[2]), 64'(exp_ready));
      chk("rnd done", 64'(rdone[2]), 64'(exp_done));
      chk("rnd busy", 64'(bsy[2]), 64'(exp_busy));
      if (exp_done != '0) begin
        chk("rnd line word", 64'(cap[2]), 64'(gword));
        inflight  = 1'b0;
        ptr       = (gidx + 1) % N;
        idle_from = cyc + 1 + 3;
      end
      if (exp_ready != '0) begin
        inflight = 1'b1;
        gidx     = sel;
        gword    = rd[2][sel];
      end
      taken = rrdy[2];
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters sharing the 32-bit UART word transmitter (2..8).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 16, meaning the minimum idle clocks between words on the transmitter (0..65535).
REQ-003 Port clk  input  1  clock; all logic is rising-edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port req_valid  input  NREQ  per-requester word-pending flag.
REQ-006 Port req_data  input  32*NREQ  requester i word at bits [32*i+31:32*i].
REQ-007 Port req_ready  output  NREQ  one-hot accept pulse; the word is taken on this cycle.
REQ-008 Port req_done  output  NREQ  one-hot pulse when that requester's word has fully left the transmitter.
REQ-009 Port tx_start  output  1  one-cycle start pulse to the word transmitter.
REQ-010 Port tx_data  output  32  word to the transmitter; byte 0 is [7:0], sent first.
REQ-011 Port tx_end  input  1  one-cycle completion pulse from the word transmitter.
REQ-012 Port busy  output  1  high in every state except IDLE.
REQ-013 Port grant_id  output  3  index of the requester currently being served.
REQ-014 Port err_spurious  output  1  sticky flag; set by tx_end outside WAIT.

Function
REQ-015 The FSM SHALL have states IDLE, START, WAIT and GAP.
REQ-016 IDLE with req_valid==0: the FSM SHALL remain in IDLE, with req_ready==0.
REQ-017 IDLE with req_valid!=0: the FSM SHALL select a requester round-robin, starting the search at pointer rr_ptr and ascending modulo NREQ.
  - Same cycle: req_ready[g] SHALL be 1, combinationally.
  - Next edge: tx_data SHALL latch req_data[g], grant_id SHALL become g, and the FSM SHALL go to START.
REQ-018 START: tx_start SHALL be 1 for exactly this one cycle, then the FSM SHALL go to WAIT.
REQ-019 tx_data and grant_id SHALL hold constant from START until the FSM returns to IDLE, because the transmitter reads tx_data continuously while it sends.
REQ-020 WAIT: on tx_end==1, in that same cycle:
  - req_done[grant_id] SHALL be 1.
  - rr_ptr SHALL become (grant_id+1) mod NREQ.
  - The next state SHALL be GAP if GAP_CYCLES>0, otherwise IDLE.
REQ-021 WAIT without tx_end: the FSM SHALL wait indefinitely, with no timeout.
REQ-022 GAP: a 16-bit counter SHALL load GAP_CYCLES-1 on entry and decrement each cycle; the FSM SHALL go to IDLE on the cycle the count is 0, giving exactly GAP_CYCLES cycles in GAP.
REQ-023 At most one word SHALL be in flight; req_ready SHALL be 0 outside IDLE.
REQ-024 A requester SHALL hold req_valid and req_data stable until it sees req_ready; dropping valid before the grant cancels the request with no side effects.
REQ-025 A requester MAY re-assert valid in the cycle after req_ready; it is then arbitrated normally at the next IDLE.
REQ-026 tx_end==1 in IDLE, START or GAP SHALL set err_spurious and SHALL NOT change state or req_done.
REQ-027 req_ready and req_done SHALL each be one-hot or zero in every cycle.

Reset
REQ-028 With reset high at an edge, the block SHALL set:
  - state IDLE, rr_ptr 0, grant_id 0;
  - tx_data 0x00000000, GAP counter 0;
  - err_spurious 0.
  Combinational outputs tx_start, req_ready, req_done and busy SHALL be 0 while in IDLE after reset.
REQ-029 Reset asserted mid-word SHALL abandon the word with no req_done; the word transmitter shares the reset and restarts at IDLE.
REQ-030 Reset SHALL take priority over tx_end and req_valid in the same cycle.

Verification
REQ-031 Single word: NREQ=4, GAP=16, req_valid=0001, data0=0xDEADBEEF ->
  - req_ready=0001 in the same cycle;
  - tx_start one cycle later, with tx_data=0xDEADBEEF held;
  - bytes EF,BE,AD,DE on the line;
  - req_done=0001 with tx_end;
  - busy for 16 more cycles.
REQ-032 Round robin: all four valid continuously, GAP=0 -> grant order 0,1,2,3,0, one word at a time, and no requester is served twice in a row.
REQ-033 Fairness after skip: rr_ptr=1, only req 3 and req 0 valid -> req 3 is served first, then req 0.
REQ-034 Gap timing: GAP=3 -> exactly 3 cycles in GAP between tx_end and the next req_ready; GAP=0 -> req_ready on the cycle after tx_end.
REQ-035 Spurious end: pulse tx_end in IDLE -> err_spurious=1 and it stays 1; no req_done; state unchanged.
REQ-036 Reset mid-word: assert reset during WAIT on byte 2 -> the next cycle has busy=0, tx_data=0, rr_ptr=0, and no req_done; a later request completes normally.
